// File: rtl/pll_reconfig_ctrl.sv
// Host-side reconfiguration controller for the Cyclone V PLL wrapper: stages counter settings,
// then writes the changed counters under PLL reset and waits for relock. Optional macro: PLL_RECONFIG_READBACK_EN.
module pll_reconfig_ctrl #(
    parameter int NUM_C        = 4,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_sel,
    input  logic [7:0]  cmd_hi,
    input  logic [7:0]  cmd_lo,
    input  logic        cmd_bypass,
    input  logic        cmd_odd,
    input  logic        apply,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
`ifdef PLL_RECONFIG_READBACK_EN
    output logic        err_verify,
`endif
    output logic        pll_rst,
    input  logic        locked,
    output logic [63:0] reconfig_to_pll,
    input  logic [63:0] reconfig_from_pll
);

    localparam int NUM_REGS = NUM_C + 2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_HOLD_RST   = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_START      = 3'd3;
    localparam logic [2:0] S_WAIT_APPLY = 3'd4;
    localparam logic [2:0] S_WAIT_LOCK  = 3'd5;
    localparam logic [2:0] S_FAIL       = 3'd6;
`ifdef PLL_RECONFIG_READBACK_EN
    localparam logic [2:0] S_READ       = 3'd7;
`endif

    localparam logic [17:0] SHADOW_RESET = 18'h10101;

    logic [2:0]          state_q, state_d;
    logic [16:0]         cnt_q, cnt_d;
    logic                lock_seen_q, lock_seen_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_timeout_q, err_timeout_d;
    logic                pll_rst_q, pll_rst_d;
    logic                wr_q, wr_d;
    logic [5:0]          addr_q, addr_d;
    logic [17:0]         wdata_q, wdata_d;
    logic                start_q, start_d;
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [17:0]         shadow_q [NUM_REGS];
    logic [17:0]         shadow_d [NUM_REGS];

    logic                scan_found;
    logic [5:0]          scan_addr;
    logic [17:0]         scan_word;
    logic                rd_bit;
    logic                waitrequest;
    logic                apply_busy;
    logic                unused_from_pll;

    assign waitrequest     = reconfig_from_pll[0];
    assign apply_busy      = reconfig_from_pll[33];
    assign unused_from_pll = ^reconfig_from_pll;

`ifdef PLL_RECONFIG_READBACK_EN
    logic        rd_q, rd_d;
    logic        err_verify_q, err_verify_d;
    logic [17:0] rdata_low;

    assign rdata_low  = reconfig_from_pll[18:1];
    assign rd_bit     = rd_q;
    assign err_verify = err_verify_q;
`else
    assign rd_bit = 1'b0;
`endif

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_timeout_q;
    assign pll_rst     = pll_rst_q;
    assign reconfig_to_pll = {23'b0, start_q, 14'b0, wdata_q, addr_q, rd_bit, wr_q};

    // Lowest-addressed dirty counter is the next one to be written.
    always_comb begin
        scan_found = 1'b0;
        scan_addr  = '0;
        scan_word  = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                scan_found = 1'b1;
                scan_addr  = 6'(i);
                scan_word  = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lock_seen_d   = lock_seen_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_timeout_d = err_timeout_q;
        pll_rst_d     = pll_rst_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        start_d       = 1'b0;
        dirty_d       = dirty_q;
        shadow_d      = shadow_q;
`ifdef PLL_RECONFIG_READBACK_EN
        rd_d          = rd_q;
        err_verify_d  = err_verify_q;
`endif

        // Out-of-range selects match no register and are silently dropped.
        if (cmd_valid && (state_q == S_IDLE)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cmd_sel == 5'(i)) begin
                    shadow_d[i] = {cmd_odd, cmd_bypass, cmd_hi, cmd_lo};
                    dirty_d[i]  = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (apply) begin
                    state_d       = S_HOLD_RST;
                    busy_d        = 1'b1;
                    err_timeout_d = 1'b0;
                    pll_rst_d     = 1'b1;
                    cnt_d         = '0;
`ifdef PLL_RECONFIG_READBACK_EN
                    err_verify_d  = 1'b0;
`endif
                end
            end
            S_HOLD_RST: begin
                if (cnt_q == 17'(RST_CYCLES - 1)) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            S_WRITE: begin
                if (wr_q) begin
                    if (!waitrequest) begin
                        wr_d = 1'b0;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == 6'(i)) begin
                                dirty_d[i] = 1'b0;
                            end
                        end
`ifdef PLL_RECONFIG_READBACK_EN
                        rd_d    = 1'b1;
                        state_d = S_READ;
`endif
                    end
                end else if (scan_found) begin
                    wr_d    = 1'b1;
                    addr_d  = scan_addr;
                    wdata_d = scan_word;
                end else begin
                    state_d = S_START;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT_APPLY;
                cnt_d   = '0;
            end
            S_WAIT_APPLY: begin
                if (!apply_busy) begin
                    pll_rst_d   = 1'b0;
                    state_d     = S_WAIT_LOCK;
                    cnt_d       = '0;
                    lock_seen_d = 1'b0;
                end else if (cnt_q == 17'(LOCK_TIMEOUT)) begin
                    state_d       = S_FAIL;
                    err_timeout_d = 1'b1;
                    busy_d        = 1'b0;
                    pll_rst_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            S_WAIT_LOCK: begin
                lock_seen_d = locked;
                if (locked && lock_seen_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (cnt_q == 17'(LOCK_TIMEOUT)) begin
                    state_d       = S_FAIL;
                    err_timeout_d = 1'b1;
                    busy_d        = 1'b0;
                    pll_rst_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
`ifdef PLL_RECONFIG_READBACK_EN
            S_READ: begin
                if (!waitrequest) begin
                    rd_d = 1'b0;
                    if (rdata_low != wdata_q) begin
                        err_verify_d = 1'b1;
                        busy_d       = 1'b0;
                        pll_rst_d    = 1'b0;
                        state_d      = S_FAIL;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lock_seen_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            pll_rst_q     <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            start_q       <= 1'b0;
            dirty_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= SHADOW_RESET;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_seen_q   <= lock_seen_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
            pll_rst_q     <= pll_rst_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            start_q       <= start_d;
            dirty_q       <= dirty_d;
            shadow_q      <= shadow_d;
        end
    end

`ifdef PLL_RECONFIG_READBACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q         <= 1'b0;
            err_verify_q <= 1'b0;
        end else begin
            rd_q         <= rd_d;
            err_verify_q <= err_verify_d;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: directed stimulus pushes expected writes, a monitor pops them.
// Covers the PLL_RECONFIG_READBACK_EN verify path when that macro is defined.
module tb_pll_reconfig_ctrl;

    localparam int NUM_C        = 4;
    localparam int RST_CYCLES   = 8;
    localparam int LOCK_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_sel;
    logic [7:0]  cmd_hi;
    logic [7:0]  cmd_lo;
    logic        cmd_bypass;
    logic        cmd_odd;
    logic        apply;
    logic        busy;
    logic        done;
    logic        err_timeout;
`ifdef PLL_RECONFIG_READBACK_EN
    logic        err_verify;
`endif
    logic        pll_rst;
    logic        locked;
    logic [63:0] reconfig_to_pll;
    logic [63:0] reconfig_from_pll;

    logic        waitreq    = 1'b0;
    logic        apply_busy = 1'b0;
    logic        bad_rdata  = 1'b0;
    int          stall_cfg  = 0;

    logic        wr_o, rd_o, start_o;
    logic [5:0]  addr_o;
    logic [31:0] wdata_o;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] wdata;
    } wr_t;

    wr_t exp_q[$];
    int  tests       = 0;
    int  fails       = 0;
    int  wr_count    = 0;
    int  start_count = 0;

    always #5 clk = ~clk;

    assign wr_o    = reconfig_to_pll[0];
    assign rd_o    = reconfig_to_pll[1];
    assign addr_o  = reconfig_to_pll[7:2];
    assign wdata_o = reconfig_to_pll[39:8];
    assign start_o = reconfig_to_pll[40];
    assign reconfig_from_pll = {30'b0, apply_busy,
                                (bad_rdata && addr_o == 6'd2) ? 32'h00000F04 : wdata_o,
                                waitreq};

    pll_reconfig_ctrl #(
        .NUM_C(NUM_C),
        .RST_CYCLES(RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel),
        .cmd_hi(cmd_hi),
        .cmd_lo(cmd_lo),
        .cmd_bypass(cmd_bypass),
        .cmd_odd(cmd_odd),
        .apply(apply),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout),
`ifdef PLL_RECONFIG_READBACK_EN
        .err_verify(err_verify),
`endif
        .pll_rst(pll_rst),
        .locked(locked),
        .reconfig_to_pll(reconfig_to_pll),
        .reconfig_from_pll(reconfig_from_pll)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic stage(input logic [4:0] sel, input logic [7:0] hi, input logic [7:0] lo,
                         input logic byp, input logic odd);
        cmd_valid  = 1'b1;
        cmd_sel    = sel;
        cmd_hi     = hi;
        cmd_lo     = lo;
        cmd_bypass = byp;
        cmd_odd    = odd;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic finish_apply(input string tag, input int nwr, input int wr0, input int st0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pll_rst) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_rst_release"}, seen, 1);
        tick();
        tick();
        locked = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, seen, 1);
        tick();
        check({tag, "_busy_clr"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_wr_cnt"}, wr_count - wr0, nwr);
        check({tag, "_start_cnt"}, start_count - st0, 1);
        check({tag, "_exp_empty"}, exp_q.size(), 0);
    endtask

    task automatic run_apply(input string tag, input int nwr);
        int wr0, st0;
        wr0 = wr_count;
        st0 = start_count;
        locked = 1'b0;
        apply  = 1'b1;
        tick();
        apply  = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_err_clr"}, err_timeout, 0);
`ifdef PLL_RECONFIG_READBACK_EN
        check({tag, "_verr_clr"}, err_verify, 0);
`endif
        finish_apply(tag, nwr, wr0, st0);
    endtask

    // PLL model: programmable waitrequest stall per transaction, apply_busy for 3 cycles after start
    initial begin : pll_model
        int stall_cnt;
        int ab_cnt;
        stall_cnt = 0;
        ab_cnt    = 0;
        forever begin
            @(negedge clk);
            if (wr_o || rd_o) begin
                if (stall_cnt < stall_cfg) begin
                    waitreq = 1'b1;
                    stall_cnt++;
                end else begin
                    waitreq = 1'b0;
                end
            end else begin
                waitreq   = 1'b0;
                stall_cnt = 0;
            end
            if (start_o) begin
                apply_busy = 1'b1;
                ab_cnt     = 3;
            end else if (ab_cnt > 0) begin
                ab_cnt--;
                if (ab_cnt == 0) apply_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic        prev_stall;
        logic        prev_start;
        logic [5:0]  prev_addr;
        logic [31:0] prev_wdata;
        wr_t         e;
        prev_stall = 1'b0;
        prev_start = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("wr_hold", wr_o, 1);
                    check("addr_hold", addr_o, prev_addr);
                    check("wdata_hold", wdata_o, prev_wdata);
                end
                if (wr_o && !waitreq) begin
                    wr_count++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL unexpected_wr: got addr 0x%0h wdata 0x%0h, want no write",
                                 addr_o, wdata_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", addr_o, e.addr);
                        check("wr_wdata", wdata_o, e.wdata);
                    end
                end
                if (start_o) begin
                    start_count++;
                    check("start_width", prev_start, 0);
                end
                prev_stall = wr_o && waitreq;
                prev_start = start_o;
                prev_addr  = addr_o;
                prev_wdata = wdata_o;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit seen;
        int k;
        int wr0, st0;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sel    = '0;
        cmd_hi     = '0;
        cmd_lo     = '0;
        cmd_bypass = 1'b0;
        cmd_odd    = 1'b0;
        apply      = 1'b0;
        locked     = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_pll_rst", pll_rst, 0);
        check("rst_bus", reconfig_to_pll, 64'h0);
        rst_n = 1'b1;
        tick();

        // single changed counter, no stalls, detailed timing
        stage(5'd2, 8'd15, 8'd5, 1'b0, 1'b0);
        exp_q.push_back('{addr: 6'd2, wdata: 32'h00000F05});
        wr0 = wr_count;
        apply = 1'b1;
        tick();
        apply = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_pll_rst", pll_rst, 1);
        check("t1_cmd_ready", cmd_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (start_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t1_start_seen", seen, 1);
        check("t1_rst_at_start", pll_rst, 1);
        tick();
        check("t1_start_one_cycle", start_o, 0);
        check("t1_rst_while_ab", pll_rst, 1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!pll_rst) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t1_rst_release", seen, 1);
        check("t1_ab_low_at_release", apply_busy, 0);
        tick();
        tick();
        locked = 1'b1;
        tick();
        check("t1_done_early", done, 0);
        tick();
        check("t1_done_2cyc", done, 1);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_busy_clr", busy, 0);
        check("t1_cmd_ready_idle", cmd_ready, 1);
        check("t1_wr_cnt", wr_count - wr0, 1);
        check("t1_exp_empty", exp_q.size(), 0);

        // M staged before N, written in ascending address order through 5-cycle stalls
        stall_cfg = 5;
        stage(5'd1, 8'd3, 8'd3, 1'b0, 1'b0);
        stage(5'd0, 8'd1, 8'd1, 1'b1, 1'b0);
        exp_q.push_back('{addr: 6'd0, wdata: 32'h00010101});
        exp_q.push_back('{addr: 6'd1, wdata: 32'h00000303});
        run_apply("t2", 2);
        stall_cfg = 0;

        // out-of-range select is dropped, so the apply has nothing to write
        stage(5'd10, 8'h44, 8'h44, 1'b0, 1'b0);
        run_apply("t3", 0);

        // lock never arrives
        locked = 1'b0;
        apply  = 1'b1;
        tick();
        apply  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!pll_rst) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t4_enter_wait_lock", seen, 1);
        k = 0;
        repeat (90) begin
            tick();
            k++;
        end
        check("t4_busy_pre", busy, 1);
        check("t4_err_pre", err_timeout, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            k++;
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_err_set", seen, 1);
        check("t4_err_cycle_in_window", (k >= 100 && k <= 102), 1);
        check("t4_busy_clr", busy, 0);
        check("t4_pll_rst_clr", pll_rst, 0);
        check("t4_no_done", done, 0);
        tick();
        check("t4_idle_ready", cmd_ready, 1);
        check("t4_err_sticky", err_timeout, 1);
        run_apply("t4b", 0);

        // commands offered while busy are refused
        stage(5'd3, 8'd2, 8'd2, 1'b0, 1'b0);
        exp_q.push_back('{addr: 6'd3, wdata: 32'h00000202});
        wr0 = wr_count;
        st0 = start_count;
        locked = 1'b0;
        apply  = 1'b1;
        tick();
        apply  = 1'b0;
        cmd_valid = 1'b1;
        cmd_sel   = 5'd4;
        cmd_hi    = 8'hAA;
        cmd_lo    = 8'hBB;
        check("t5_ready_busy0", cmd_ready, 0);
        tick();
        check("t5_ready_busy1", cmd_ready, 0);
        cmd_valid = 1'b0;
        finish_apply("t5", 1, wr0, st0);
        run_apply("t5b", 0);

        // command and apply in the same cycle: command is part of this apply
        wr0 = wr_count;
        st0 = start_count;
        locked     = 1'b0;
        cmd_valid  = 1'b1;
        cmd_sel    = 5'd5;
        cmd_hi     = 8'd0;
        cmd_lo     = 8'd0;
        cmd_bypass = 1'b0;
        cmd_odd    = 1'b1;
        apply      = 1'b1;
        exp_q.push_back('{addr: 6'd5, wdata: 32'h00020000});
        tick();
        cmd_valid = 1'b0;
        cmd_odd   = 1'b0;
        apply     = 1'b0;
        finish_apply("t7", 1, wr0, st0);

        // reset during a stalled write abandons it and restores defaults
        stall_cfg = 5;
        stage(5'd4, 8'd9, 8'd8, 1'b0, 1'b0);
        locked = 1'b0;
        apply  = 1'b1;
        tick();
        apply  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wr_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t6_wr_seen", seen, 1);
        tick();
        tick();
        check("t6_stalling", waitreq, 1);
        rst_n = 1'b0;
        tick();
        check("t6_wr_drop", wr_o, 0);
        check("t6_pll_rst", pll_rst, 0);
        check("t6_busy", busy, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_bus_zero", reconfig_to_pll, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        stall_cfg = 0;
        run_apply("t6b", 0);

`ifdef PLL_RECONFIG_READBACK_EN
        // readback returns a corrupted low count for C0
        stage(5'd2, 8'd15, 8'd5, 1'b0, 1'b0);
        exp_q.push_back('{addr: 6'd2, wdata: 32'h00000F05});
        bad_rdata = 1'b1;
        wr0 = wr_count;
        st0 = start_count;
        locked = 1'b0;
        apply  = 1'b1;
        tick();
        apply  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (err_verify) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t8_verr_set", seen, 1);
        check("t8_busy_clr", busy, 0);
        check("t8_pll_rst_clr", pll_rst, 0);
        check("t8_no_tmo", err_timeout, 0);
        tick();
        check("t8_no_start", start_count - st0, 0);
        check("t8_wr_cnt", wr_count - wr0, 1);
        check("t8_idle_ready", cmd_ready, 1);
        check("t8_verr_sticky", err_verify, 1);
        bad_rdata = 1'b0;
        run_apply("t8b", 0);
`endif

        tick();
        check("final_exp_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
